// File: rtl/ps2_pkg.sv
// Shared PS/2 byte constants, decoder FSM encoding and a control-byte classifier.
// The optional held-key table is enabled by defining PS2_TYPEMATIC_FILTER_EN.
package ps2_pkg;

  localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK   = 8'hF0;
  localparam logic [7:0] PS2_KEY_SPACE = 8'h29;
  localparam logic [7:0] PS2_KEY_ESC   = 8'h76;
  localparam logic [7:0] PS2_BAT       = 8'hAA;
  localparam logic [7:0] PS2_ACK       = 8'hFA;
  localparam logic [7:0] PS2_ECHO      = 8'hEE;
  localparam logic [7:0] PS2_RESEND    = 8'hFE;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DECODE = 2'd2
  } ps2_state_e;

  // Keyboard status replies: never key events, and they end any prefix sequence.
  function automatic logic is_ctrl_byte(input logic [7:0] b);
    return (b == PS2_BAT) || (b == PS2_ACK) || (b == PS2_ECHO) || (b == PS2_RESEND);
  endfunction

endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// Upstream PS/2 receiver FIFO port: head byte, non-empty, overflow and active-low pop.
interface ps2_scancode_decoder_if;
  logic [7:0] kb_data;
  logic       kb_ready;
  logic       kb_overflow;
  logic       kb_rdn;

  modport master (output kb_data, output kb_ready, output kb_overflow, input kb_rdn);
  modport slave  (input kb_data, input kb_ready, input kb_overflow, output kb_rdn);
endinterface

// File: rtl/ps2_key_table.sv
// 256-entry held-key bitmap used to drop typematic repeats.
// Only present when PS2_TYPEMATIC_FILTER_EN is defined.
`ifdef PS2_TYPEMATIC_FILTER_EN
module ps2_key_table (
  input  logic       clk,
  input  logic       rst,
  input  logic       set,
  input  logic       clr,
  input  logic [7:0] addr,
  output logic       held
);

  logic [255:0] held_q;
  logic [255:0] held_d;

  // Next-state of the bitmap: set wins over clear for the addressed entry.
  always_comb begin
    held_d = held_q;
    if (set) begin
      held_d[addr] = 1'b1;
    end else if (clr) begin
      held_d[addr] = 1'b0;
    end else begin
      held_d = held_q;
    end
  end

  // Bitmap register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_q <= 256'd0;
    end else begin
      held_q <= held_d;
    end
  end

  assign held = held_q[addr];

endmodule
`endif

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan code decoder: pops bytes from the receiver FIFO, strips E0/F0
// prefixes and emits key events. PS2_TYPEMATIC_FILTER_EN enables repeat filtering.
module ps2_scancode_decoder
  import ps2_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  ps2_scancode_decoder_if.slave        kb,
  output logic                         key_valid,
  output logic [7:0]                   key_code,
  output logic                         key_ext,
  output logic                         key_break,
  output logic                         space_down,
  output logic                         esc_down,
  output logic                         ovf_seen
);

  ps2_state_e state_q, state_d;
  logic [7:0] code_q, code_d;
  logic       ext_q, ext_d, brk_q, brk_d;
  logic       kb_rdn_q, kb_rdn_d;
  logic       key_valid_q, key_valid_d;
  logic [7:0] key_code_q, key_code_d;
  logic       key_ext_q, key_ext_d, key_break_q, key_break_d;
  logic       space_q, space_d, esc_q, esc_d, ovf_q, ovf_d;
  logic       ext_eff_s, brk_eff_s, suppress_s;

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic tbl_set_s, tbl_clr_s, tbl_held_s;

  ps2_key_table u_key_table (
    .clk  (clk),
    .rst  (rst),
    .set  (tbl_set_s),
    .clr  (tbl_clr_s),
    .addr (code_q),
    .held (tbl_held_s)
  );
`endif

  // Next-state and event decode; an overflow in the same cycle voids any prefix.
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    ext_eff_s   = ext_q & ~kb.kb_overflow;
    brk_eff_s   = brk_q & ~kb.kb_overflow;
    ext_d       = ext_eff_s;
    brk_d       = brk_eff_s;
    kb_rdn_d    = 1'b1;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_break_d = key_break_q;
    space_d     = space_q;
    esc_d       = esc_q;
    ovf_d       = ovf_q | kb.kb_overflow;
    suppress_s  = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
    tbl_set_s   = 1'b0;
    tbl_clr_s   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (kb.kb_ready) begin
          code_d   = kb.kb_data;
          kb_rdn_d = 1'b0;
          state_d  = FETCH;
        end else begin
          state_d  = IDLE;
        end
      end
      FETCH: begin
        state_d = DECODE;
      end
      DECODE: begin
        state_d = IDLE;
        if (code_q == PS2_PFX_EXT) begin
          ext_d = 1'b1;
        end else if (code_q == PS2_PFX_BRK) begin
          brk_d = 1'b1;
        end else if (is_ctrl_byte(code_q)) begin
          ext_d = 1'b0;
          brk_d = 1'b0;
        end else begin
          ext_d = 1'b0;
          brk_d = 1'b0;
          if (!ext_eff_s && (code_q == PS2_KEY_SPACE)) begin
            space_d = ~brk_eff_s;
          end else begin
            space_d = space_q;
          end
          if (!ext_eff_s && (code_q == PS2_KEY_ESC)) begin
            esc_d = ~brk_eff_s;
          end else begin
            esc_d = esc_q;
          end
`ifdef PS2_TYPEMATIC_FILTER_EN
          tbl_set_s  = ~ext_eff_s & ~brk_eff_s;
          tbl_clr_s  = ~ext_eff_s & brk_eff_s;
          suppress_s = tbl_set_s & tbl_held_s;
`endif
          if (!suppress_s) begin
            key_valid_d = 1'b1;
            key_code_d  = code_q;
            key_ext_d   = ext_eff_s;
            key_break_d = brk_eff_s;
          end else begin
            key_valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; pop strobe is a flop so it cannot glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      code_q      <= 8'h00;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      kb_rdn_q    <= 1'b1;
      key_valid_q <= 1'b0;
      key_code_q  <= 8'h00;
      key_ext_q   <= 1'b0;
      key_break_q <= 1'b0;
      space_q     <= 1'b0;
      esc_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      kb_rdn_q    <= kb_rdn_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_ext_q   <= key_ext_d;
      key_break_q <= key_break_d;
      space_q     <= space_d;
      esc_q       <= esc_d;
      ovf_q       <= ovf_d;
    end
  end

  assign kb.kb_rdn  = kb_rdn_q;
  assign key_valid  = key_valid_q;
  assign key_code   = key_code_q;
  assign key_ext    = key_ext_q;
  assign key_break  = key_break_q;
  assign space_down = space_q;
  assign esc_down   = esc_q;
  assign ovf_seen   = ovf_q;

endmodule
